program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/sap_pkg.sv | 15 +
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared SAP definitions: loader state encoding and program RAM geometry.
package sap_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int RAM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams host bytes into the SAP program RAM, one write every two cycles,
// holding the CPU in clear while a load is in progress.
module program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              end_load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_clr_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(RAM_DEPTH - 1);

    load_state_t state;
    load_state_t next_state;
    logic        end_pending;
    logic        hold_cpu;
    logic        last_write;

    // A write is the last one if the host asked to stop with it or the RAM is full.
    assign last_write = end_pending || (byte_count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (data_valid) begin
                    next_state = ST_WRITE;
                end else if (end_load) begin
                    next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                next_state = last_write ? ST_DONE : ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        data_ready = 1'b0;
        ram_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                data_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                ram_we = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // The CPU stays cleared through the reset edge itself, then follows busy.
    always_ff @(posedge clk) begin
        hold_cpu <= !clr_n;
    end

    assign cpu_clr_n = !(hold_cpu || busy);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ram_addr    <= '0;
            ram_wdata   <= '0;
            byte_count  <= '0;
            checksum    <= '0;
            end_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ram_addr    <= '0;
                        byte_count  <= '0;
                        checksum    <= '0;
                        end_pending <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (data_valid) begin
                        ram_wdata   <= data_in;
                        end_pending <= end_load;
                    end
                end
                ST_WRITE: begin
                    checksum   <= checksum + ram_wdata;
                    byte_count <= byte_count + (ADDR_W + 1)'(1);
                    if (!last_write) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a transfer-level model checked every cycle, plus
// directed load scenarios with hand-computed results.
module tb_program_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              start;
    logic              end_load;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_clr_n;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   byte_count;
    logic [DATA_W-1:0] checksum;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .end_load  (end_load),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_clr_n (cpu_clr_n),
        .busy      (busy),
        .done      (done),
        .byte_count(byte_count),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Transfer-level model: a loading session, a pending write, and the
    // running count/sum of bytes written; the next address is the count.
    logic        armed = 1'b0;
    logic        m_rst, m_busy, m_done, m_wr, m_end;
    logic [4:0]  m_count;
    logic [7:0]  m_sum, m_wdata;
    logic [3:0]  m_addr;
    int          cycle = 0;

    always @(posedge clk) begin
        cycle++;
        if (!clr_n) begin
            armed = 1'b1;
            m_rst = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_end = 1'b0;
            m_count = '0; m_sum = '0; m_addr = '0; m_wdata = '0;
        end else if (armed) begin
            m_rst = 1'b0;
            if (m_wr) begin
                m_sum   = m_sum + m_wdata;
                m_count = m_count + 5'd1;
                m_wr    = 1'b0;
                if (m_end || m_count == 5'd16) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_addr = m_count[3:0];
                end
            end else if (m_busy) begin
                if (data_valid) begin
                    m_wr    = 1'b1;
                    m_wdata = data_in;
                    m_end   = end_load;
                end else if (end_load) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_busy = 1'b1; m_done = 1'b0; m_end = 1'b0;
                m_count = '0; m_sum = '0; m_addr = '0;
            end
        end
    end

    logic [7:0] mem [16];
    int         we_log[$];
    logic       prev_we = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ram_we", ram_we, m_wr);
            checkOutput("data_ready", data_ready, m_busy && !m_wr);
            checkOutput("busy", busy, m_busy);
            checkOutput("done", done, m_done);
            checkOutput("cpu_clr_n", cpu_clr_n, !m_rst && !m_busy);
            checkOutput("byte_count", byte_count, m_count);
            checkOutput("checksum", checksum, m_sum);
            checkOutput("we_back_to_back", ram_we && prev_we, 1'b0);
            if (m_wr || m_rst) begin
                checkOutput("ram_addr", ram_addr, m_addr);
                checkOutput("ram_wdata", ram_wdata, m_wdata);
            end
            if (ram_we) begin
                mem[ram_addr] = ram_wdata;
                we_log.push_back(cycle);
            end
            prev_we = ram_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic v,
                                 input logic [7:0] d);
        start      = s;
        end_load   = e;
        data_valid = v;
        data_in    = d;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!data_ready && n < 8) begin
            tick();
            n++;
        end
        if (!data_ready) checkOutput("ready_timeout", data_ready, 1'b1);
    endtask

    task automatic pulse_start();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        applyStimulus(1'b0, e, 1'b1, b);
        wait_ready();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("we_after_handshake", ram_we, 1'b1);
        tick();
    endtask

    task automatic end_only();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first;
        clr_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_cpu_clr_n", cpu_clr_n, 1'b0);
        checkOutput("rst_byte_count", byte_count, 5'd0);
        clr_n = 1'b1;
        tick();
        checkOutput("release_cpu_clr_n", cpu_clr_n, 1'b1);

        $display("[TB] full 16-byte load");
        pulse_start();
        first = we_log.size();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i));
            wait_ready();
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("full_done", done, 1'b1);
        checkOutput("full_count", byte_count, 5'd16);
        checkOutput("full_checksum", checksum, 8'h78);
        checkOutput("full_pulses", we_log.size() - first, 16);
        checkOutput("full_span", we_log[we_log.size() - 1] - we_log[first], 30);
        checkOutput("full_mem15", mem[15], 8'h0F);
        checkOutput("full_mem7", mem[7], 8'h07);

        $display("[TB] early end after three bytes");
        pulse_start();
        send_byte(8'h0A, 1'b0);
        send_byte(8'h1B, 1'b0);
        send_byte(8'hE0, 1'b0);
        end_only();
        checkOutput("early_done", done, 1'b1);
        checkOutput("early_count", byte_count, 5'd3);
        checkOutput("early_checksum", checksum, 8'h05);
        checkOutput("early_cpu_clr_n", cpu_clr_n, 1'b1);

        $display("[TB] end together with a transfer");
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h55, 1'b1);
        checkOutput("endxfer_done", done, 1'b1);
        checkOutput("endxfer_count", byte_count, 5'd2);
        checkOutput("endxfer_checksum", checksum, 8'h56);
        checkOutput("endxfer_mem1", mem[1], 8'h55);

        $display("[TB] reset during write of byte 5");
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h14);
        wait_ready();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_in_write", ram_we, 1'b1);
        clr_n = 1'b0;
        tick();
        checkOutput("abort_we", ram_we, 1'b0);
        checkOutput("abort_ready", data_ready, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_addr", ram_addr, 4'd0);
        checkOutput("abort_wdata", ram_wdata, 8'h00);
        checkOutput("abort_count", byte_count, 5'd0);
        checkOutput("abort_checksum", checksum, 8'h00);
        checkOutput("abort_cpu_clr_n", cpu_clr_n, 1'b0);
        clr_n = 1'b1;
        tick();
        checkOutput("abort_release_cpu_clr_n", cpu_clr_n, 1'b1);

        $display("[TB] ignored start and data_valid");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("idle_valid_count", byte_count, 5'd0);
        pulse_start();
        send_byte(8'h33, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("midload_start_busy", busy, 1'b1);
        checkOutput("midload_start_count", byte_count, 5'd1);
        send_byte(8'h44, 1'b0);
        end_only();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("done_valid_count", byte_count, 5'd2);
        checkOutput("done_valid_checksum", checksum, 8'h77);
        checkOutput("done_valid_done", done, 1'b1);

        $display("[TB] back-to-back load");
        pulse_start();
        checkOutput("b2b_done_cleared", done, 1'b0);
        send_byte(8'hFF, 1'b0);
        end_only();
        checkOutput("b2b_count", byte_count, 5'd1);
        checkOutput("b2b_checksum", checksum, 8'hFF);
        checkOutput("b2b_mem0", mem[0], 8'hFF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
